audio_track_sequencer: RTL

Plays the two-part spoken announcement for the color-recognizer audio path. A keyboard strobe selects red or green, and the block streams two clips from the sample ROM to the audio codec: first the number word for the current count, then the color word. It sits between the keyboard decoder / color counter (inputs) and the codec write FIFO (output), inside the audio manager.

---
 rtl/audio_track_pkg.sv | 32 +++
 rtl/track_lookup.sv | 17 +
 rtl/audio_track_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/audio_track_pkg.sv
// Shared definitions for the announcement sequencer: FSM states, colour tracks and the
// clip table (base word address + length in samples) also used by the ROM image generator.
package audio_track_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  typedef logic [2:0]  track_idx_t;
  typedef logic [16:0] track_base_t;
  typedef logic [15:0] track_len_t;

  localparam track_idx_t  TRACK_RED   = 3'd6;
  localparam track_idx_t  TRACK_GREEN = 3'd7;
  localparam int unsigned MAX_COUNT   = 5;

  // "zero".."five", "red", "green"; "four" is an empty clip, "green" ends at the top of the ROM
  localparam track_base_t TRACK_BASE [8] = '{
    17'h00000, 17'h00100, 17'h00200, 17'h00300,
    17'h00400, 17'h10000, 17'h08000, 17'h1FFFC
  };
  localparam track_len_t TRACK_LEN [8] = '{
    16'd5, 16'd3, 16'd6, 16'd4,
    16'd0, 16'd7, 16'd5, 16'd4
  };

endpackage

// File: rtl/track_lookup.sv
// Combinational clip table lookup: track index -> {base word address, length in samples}.
module track_lookup
  import audio_track_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic [2:0]        track,
  output logic [ADDR_W-1:0] base,
  output track_len_t        len
);

  always_comb begin
    base = ADDR_W'(TRACK_BASE[track]);
    len  = TRACK_LEN[track];
  end

endmodule

// File: rtl/audio_track_sequencer.sv
// Streams the number clip then the colour clip from the sample ROM to the codec FIFO.
// Define ATS_GAP_EN to insert GAP_SAMPLES zero samples between the two clips.
module audio_track_sequencer
  import audio_track_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int CNT_W       = 4,
  parameter int GAP_SAMPLES = 2400
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_r,
  input  logic              key_g,
  input  logic [CNT_W-1:0]  red_count,
  input  logic [CNT_W-1:0]  green_count,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [23:0]       sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy
);

`ifdef ATS_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  state_t            state;
  state_t            after_clip;
  logic              phase;
  logic [2:0]        num_track;
  logic [2:0]        color_track;
  logic [2:0]        cur_track;
  logic [2:0]        trig_num;
  logic [CNT_W-1:0]  sel_count;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] tbl_base;
  track_len_t        tbl_len;
  track_len_t        remaining;
  logic [31:0]       gap_cnt;
  logic              clip_end;

  assign rom_addr  = addr;
  assign cur_track = phase ? color_track : num_track;

  track_lookup #(.ADDR_W(ADDR_W)) u_lookup (
    .track (cur_track),
    .base  (tbl_base),
    .len   (tbl_len)
  );

  always_comb begin
    sel_count = key_r ? red_count : green_count;
    trig_num  = (32'(sel_count) > MAX_COUNT) ? 3'(MAX_COUNT) : 3'(sel_count);
    if (phase)                              after_clip = ST_IDLE;
    else if (GAP_EN && (GAP_SAMPLES > 0))   after_clip = ST_GAP;
    else                                    after_clip = ST_LOAD;
    clip_end = ((state == ST_LOAD) && (tbl_len == '0)) ||
               ((state == ST_PRESENT) && sample_ready && (remaining == 16'd1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      phase        <= 1'b0;
      num_track    <= '0;
      color_track  <= '0;
      addr         <= '0;
      remaining    <= '0;
      gap_cnt      <= '0;
      rom_rd       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_r || key_g) begin
            num_track   <= trig_num;
            color_track <= key_r ? TRACK_RED : TRACK_GREEN;
            phase       <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          addr      <= tbl_base;
          remaining <= tbl_len;
          rom_rd    <= 1'b1;
          state     <= ST_FETCH;
        end
        ST_FETCH: begin
          rom_rd <= 1'b0;
          state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sample       <= {rom_data, 8'h00};
          sample_valid <= 1'b1;
          state        <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (sample_ready) begin
            addr         <= addr + 1'b1;
            remaining    <= remaining - 1'b1;
            sample_valid <= 1'b0;
            rom_rd       <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_GAP: begin
          if (sample_ready) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == 32'd1) begin
              sample_valid <= 1'b0;
              state        <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Clip completion (including an empty clip at LOAD) overrides the per-state assignments above
      if (clip_end) begin
        state        <= after_clip;
        phase        <= 1'b1;
        rom_rd       <= 1'b0;
        sample       <= '0;
        sample_valid <= (after_clip == ST_GAP);
        busy         <= (after_clip != ST_IDLE);
        gap_cnt      <= 32'(GAP_SAMPLES);
      end
    end
  end

endmodule
